// File: rtl/bist_pkg.sv
// Shared types and March C- element table for the BIST controller.
package bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    // Background bit, replicated across the data word by the controller
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    // One March element: direction plus up to two operations per address
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_bg;
        logic op1_wr;
        logic op1_bg;
    } elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t r;
        r = '0;
        case (e)
            E0:      r = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_bg: BG0, op1_wr: 1'b0, op1_bg: BG0};
            E1:      r = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b1, op1_bg: BG1};
            E2:      r = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG1, op1_wr: 1'b1, op1_bg: BG0};
            E3:      r = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b1, op1_bg: BG1};
            E4:      r = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG1, op1_wr: 1'b1, op1_bg: BG0};
            default: r = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b0, op1_bg: BG0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter with terminal-count flag for March elements.
module bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              load_down_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    import bist_pkg::*;

    logic [ADDR_W-1:0] addr_q;

    // Load the start address of an element, or step toward its terminal address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= load_down_i ? '1 : '0;
        end else if (step_i) begin
            addr_q <= down_i ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- BIST controller: sequences SRAM reads/writes and records the first mismatch.
module bist_march_ctrl
    import bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem
);

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    logic              ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    elem_t             cur, nxt;
    logic [2:0]        nxt_elem;
    logic              run, cur_wr, cur_bg, last_op, rd_miss;
    logic [DATA_W-1:0] bg_word;

    assign nxt_elem = elem_q + 3'd1;
    assign cur      = elem_info(elem_q);
    assign nxt      = elem_info(nxt_elem);
    assign run      = (state_q == S_RUN);
    assign cur_wr   = op_q ? cur.op1_wr : cur.op0_wr;
    assign cur_bg   = op_q ? cur.op1_bg : cur.op0_bg;
    assign bg_word  = {DATA_W{cur_bg}};
    assign last_op  = !cur.two_ops || op_q;
    assign rd_miss  = run && !cur_wr && (mem_dout != bg_word);

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ag_load),
        .load_down_i (ag_load_down),
        .step_i      (ag_step),
        .down_i      (cur.down),
        .addr_o      (ag_addr),
        .last_o      (ag_last)
    );

    // State, element/op position and first-failure record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_q      <= E0;
            op_q        <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // Next-state: op -> address -> element sequencing and mismatch capture
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        op_d         = op_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_elem_d  = fail_elem_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    elem_d       = E0;
                    op_d         = 1'b0;
                    ag_load      = 1'b1;
                    ag_load_down = 1'b0;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                    fail_elem_d  = '0;
                end
            end
            S_RUN: begin
                // Only the first mismatch of a run is recorded
                if (rd_miss && !fail_q) begin
                    fail_d      = 1'b1;
                    fail_addr_d = ag_addr;
                    fail_data_d = mem_dout;
                    fail_elem_d = elem_q;
                end
                if (last_op) begin
                    op_d = 1'b0;
                    if (ag_last) begin
                        if (elem_q == E5) begin
                            state_d = S_DONE;
                        end else begin
                            elem_d       = nxt_elem;
                            ag_load      = 1'b1;
                            ag_load_down = nxt.down;
                        end
                    end else begin
                        ag_step = 1'b1;
                    end
                end else begin
                    op_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = run;
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;
    assign mem_we    = run && cur_wr;
    assign mem_addr  = run ? ag_addr : '0;
    assign mem_din   = run ? bg_word : '0;

endmodule
